// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store unit: FSM states, error codes,
// funct3 access types and the command legality check.
package corePckg;

    typedef enum logic [1:0] {
        eIdle   = 2'b00,
        eAccess = 2'b01,
        eWb     = 2'b10
    } tLsuState;

    typedef enum logic [1:0] {
        eErrNone     = 2'b00,
        eErrMisalign = 2'b01,
        eErrIllegal  = 2'b10,
        eErrTimeout  = 2'b11
    } tLsuErr;

    localparam logic [2:0] cLsuB  = 3'b000;
    localparam logic [2:0] cLsuH  = 3'b001;
    localparam logic [2:0] cLsuW  = 3'b010;
    localparam logic [2:0] cLsuBU = 3'b100;
    localparam logic [2:0] cLsuHU = 3'b101;

    // Illegal takes priority over misaligned.
    function automatic tLsuErr lsu_check(logic rd, logic wr, logic [2:0] op, logic [1:0] addr_lo);
        tLsuErr res;
        res = eErrNone;
        if (rd == wr)
            res = eErrIllegal;
        else if (rd && !(op inside {cLsuB, cLsuH, cLsuW, cLsuBU, cLsuHU}))
            res = eErrIllegal;
        else if (wr && !(op inside {cLsuB, cLsuH, cLsuW}))
            res = eErrIllegal;
        else if ((op[1:0] == 2'b01 && addr_lo[0]) || (op[1:0] == 2'b10 && addr_lo != 2'b00))
            res = eErrMisalign;
        return res;
    endfunction

endpackage

// File: rtl/lsu_ctrl_lane.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// and load lane extraction with sign/zero extension.
module lsu_lane
    import corePckg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op_type,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    function automatic logic [31:0] extend(logic [31:0] raw, logic [1:0] size, logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = raw[7:0];
        h = raw[15:0];
        case (size)
            2'b00:   s = uns ? $signed({24'd0, raw[7:0]})  : b;
            2'b01:   s = uns ? $signed({16'd0, raw[15:0]}) : h;
            default: s = raw;
        endcase
        return s;
    endfunction

    logic [31:0] shifted;

    always_comb begin
        be      = 4'b1111;
        wdata   = st_data;
        case (op_type[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = rdata >> {addr_lo, 3'b000};
    assign ld_data = extend(shifted, op_type[1:0], op_type[2]);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the ALU memory-op output and the data-memory port.
// Optional ACCESS timeout is compiled in when LSU_TIMEOUT_EN is defined.
module lsu_ctrl
    import corePckg::*;
#(
    parameter int cDataWidth     = 32,
    parameter int cAddrWidth     = 32,
    parameter int cTimeoutCycles = 16
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    input  logic                  iRead,
    input  logic                  iWrite,
    input  logic [2:0]            iOpType,
    input  logic [cAddrWidth-1:0] iAddr,
    input  logic [cDataWidth-1:0] iData,
    input  logic [4:0]            iRdAddr,
    output logic                  oBusy,
    output logic                  oMemReq,
    output logic                  oMemWe,
    output logic [cAddrWidth-1:0] oMemAddr,
    output logic [cDataWidth-1:0] oMemWdata,
    output logic [3:0]            oMemBe,
    input  logic                  iMemAck,
    input  logic [cDataWidth-1:0] iMemRdata,
    output logic                  oRegWrite,
    output logic [4:0]            oRegAddr,
    output logic [cDataWidth-1:0] oRegData,
    output logic                  oErr,
    output logic [1:0]            oErrCode
);

    tLsuState              state, state_nxt;
    tLsuErr                cmd_err, err_code_q;
    logic                  err_q;
    logic                  accept, timeout;
    logic [cAddrWidth-1:0] addr_q;
    logic [2:0]            op_q;
    logic                  we_q;
    logic [cDataWidth-1:0] wdata_q, load_q;
    logic [4:0]            rd_q;
    logic [3:0]            lane_be;
    logic [cDataWidth-1:0] lane_wdata, lane_ld;

    assign cmd_err = lsu_check(iRead, iWrite, iOpType, iAddr[1:0]);
    assign accept  = (state == eIdle) && iValid && (cmd_err == eErrNone);

    lsu_lane u_lane (
        .addr_lo (addr_q[1:0]),
        .op_type (op_q),
        .st_data (wdata_q),
        .rdata   (iMemRdata),
        .be      (lane_be),
        .wdata   (lane_wdata),
        .ld_data (lane_ld)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int cCntW = $clog2(cTimeoutCycles + 1);
    logic [cCntW-1:0] cnt;

    // cnt holds the number of ACCESS cycles already elapsed before this one.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)                cnt <= '0;
        else if (state != eAccess) cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end

    assign timeout = (state == eAccess) && !iMemAck && (cnt == cCntW'(cTimeoutCycles - 1));
`else
    assign timeout = 1'b0;
`endif

    // ---- state register ----
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= eIdle;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            eIdle:   if (accept) state_nxt = eAccess;
            eAccess: begin
                if (iMemAck)      state_nxt = we_q ? eIdle : eWb;
                else if (timeout) state_nxt = eIdle;
            end
            eWb:     state_nxt = eIdle;
            default: state_nxt = eIdle;
        endcase
    end

    // ---- error pulse register ----
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            err_q      <= 1'b0;
            err_code_q <= eErrNone;
        end else begin
            err_q      <= 1'b0;
            err_code_q <= eErrNone;
            if (state == eIdle && iValid && cmd_err != eErrNone) begin
                err_q      <= 1'b1;
                err_code_q <= cmd_err;
            end else if (timeout) begin
                err_q      <= 1'b1;
                err_code_q <= eErrTimeout;
            end
        end
    end

    // ---- command / load-data registers (datapath, no reset; outputs are gated by state) ----
    always_ff @(posedge iClk) begin
        if (accept) begin
            addr_q  <= iAddr;
            op_q    <= iOpType;
            we_q    <= iWrite;
            wdata_q <= iData;
            rd_q    <= iRdAddr;
        end
        if (state == eAccess && iMemAck && !we_q)
            load_q <= lane_ld;
    end

    always_comb begin
        oBusy     = 1'b0;
        oMemReq   = 1'b0;
        oMemWe    = 1'b0;
        oMemAddr  = '0;
        oMemBe    = '0;
        oMemWdata = '0;
        oRegWrite = 1'b0;
        oRegAddr  = '0;
        oRegData  = '0;
        case (state)
            eAccess: begin
                oBusy    = 1'b1;
                oMemReq  = 1'b1;
                oMemWe   = we_q;
                oMemAddr = {addr_q[cAddrWidth-1:2], 2'b00};
                oMemBe   = lane_be;
                if (we_q) oMemWdata = lane_wdata;
            end
            eWb: begin
                oBusy = 1'b1;
                if (rd_q != 5'd0) begin
                    oRegWrite = 1'b1;
                    oRegAddr  = rd_q;
                    oRegData  = load_q;
                end
            end
            default: ;
        endcase
    end

    assign oErr     = err_q;
    assign oErrCode = err_code_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases, back-to-back streams,
// reset during ACCESS and randomized commands against a byte-level reference model.
module tb_lsu_ctrl;

    logic        iClk = 1'b0, iRst = 1'b0, iValid = 1'b0, iRead = 1'b0, iWrite = 1'b0;
    logic [2:0]  iOpType = 3'd0;
    logic [31:0] iAddr = 32'd0, iData = 32'd0, iMemRdata = 32'd0;
    logic [4:0]  iRdAddr = 5'd0;
    logic        iMemAck = 1'b0;
    logic        oBusy, oMemReq, oMemWe, oRegWrite, oErr;
    logic [31:0] oMemAddr, oMemWdata, oRegData;
    logic [3:0]  oMemBe;
    logic [4:0]  oRegAddr;
    logic [1:0]  oErrCode;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_ctrl #(.cDataWidth(32), .cAddrWidth(32), .cTimeoutCycles(4)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iRead(iRead), .iWrite(iWrite),
        .iOpType(iOpType), .iAddr(iAddr), .iData(iData), .iRdAddr(iRdAddr),
        .oBusy(oBusy), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemWdata(oMemWdata), .oMemBe(oMemBe), .iMemAck(iMemAck), .iMemRdata(iMemRdata),
        .oRegWrite(oRegWrite), .oRegAddr(oRegAddr), .oRegData(oRegData),
        .oErr(oErr), .oErrCode(oErrCode)
    );

    always #5 iClk = ~iClk;

    // Reference model: accesses described as a run of 'size' bytes starting at addr.
    function automatic logic [1:0] m_err(bit rd, bit wr, logic [2:0] op, logic [31:0] a);
        int size;
        if (rd == wr) return 2'd2;
        if (rd && (op == 3 || op == 6 || op == 7)) return 2'd2;
        if (wr && op >= 3) return 2'd2;
        size = 1 << op[1:0];
        if ((a % size) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] op, logic [31:0] a);
        int size, off;
        logic [3:0] r;
        size = 1 << op[1:0];
        off  = int'(a % 4);
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + size);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] op, logic [31:0] d);
        int size;
        logic [31:0] r;
        size = 1 << op[1:0];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % size) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] op, logic [31:0] a, logic [31:0] rdata);
        int size, off;
        logic [63:0] v, mask;
        size = 1 << op[1:0];
        off  = int'(a % 4);
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = (64'(rdata) >> (8 * off)) & mask;
        if (op < 4 && size < 4 && v[8*size-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One command from presentation to completion, ack after 'waits' ACCESS cycles.
    task automatic run_txn(input string nm, input bit rd, input bit wr, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdn,
                           input int waits, input logic [31:0] rdata);
        logic [1:0] e;
        e = m_err(rd, wr, op, a);
        @(negedge iClk);
        iValid = 1'b1; iRead = rd; iWrite = wr; iOpType = op; iAddr = a; iData = d; iRdAddr = rdn;
        @(posedge iClk); #1;
        iValid = 1'b0; iRead = 1'b0; iWrite = 1'b0;
        if (e != 2'd0) begin
            @(negedge iClk);
            n_checks++;
            if (oErr !== 1'b1 || oErrCode !== e) begin
                n_fail++; $display("FAIL %s err: got %0b/%0d want 1/%0d", nm, oErr, oErrCode, e);
            end
            n_checks++;
            if (oMemReq !== 1'b0 || oBusy !== 1'b0) begin
                n_fail++; $display("FAIL %s err_idle: req %0b busy %0b want 0 0", nm, oMemReq, oBusy);
            end
            @(negedge iClk);
            n_checks++;
            if (oErr !== 1'b0) begin
                n_fail++; $display("FAIL %s err_pulse: got %0b want 0", nm, oErr);
            end
            return;
        end
        for (int w = 0; w <= waits; w++) begin
            @(negedge iClk);
            n_checks++;
            if (oMemReq !== 1'b1 || oBusy !== 1'b1 || oMemWe !== wr || oErr !== 1'b0) begin
                n_fail++;
                $display("FAIL %s access[%0d]: req %0b busy %0b we %0b err %0b want 1 1 %0b 0",
                         nm, w, oMemReq, oBusy, oMemWe, oErr, wr);
            end
            n_checks++;
            if (oMemAddr !== {a[31:2], 2'b00} || oMemBe !== m_be(op, a)) begin
                n_fail++;
                $display("FAIL %s addr_be[%0d]: got %h/%b want %h/%b", nm, w, oMemAddr, oMemBe,
                         {a[31:2], 2'b00}, m_be(op, a));
            end
            if (wr) begin
                n_checks++;
                if (oMemWdata !== m_wdata(op, d)) begin
                    n_fail++; $display("FAIL %s wdata[%0d]: got %h want %h", nm, w, oMemWdata, m_wdata(op, d));
                end
            end
            iMemAck   = (w == waits);
            iMemRdata = (w == waits) ? rdata : $urandom;
            @(posedge iClk); #1;
            iMemAck   = 1'b0;
            iMemRdata = $urandom;
        end
        @(negedge iClk);
        if (wr) begin
            n_checks++;
            if (oBusy !== 1'b0 || oMemReq !== 1'b0 || oRegWrite !== 1'b0) begin
                n_fail++; $display("FAIL %s store_done: busy %0b req %0b rw %0b want 0 0 0", nm, oBusy, oMemReq, oRegWrite);
            end
        end else begin
            n_checks++;
            if (oRegWrite !== (rdn != 5'd0) || oBusy !== 1'b1 || oMemReq !== 1'b0) begin
                n_fail++;
                $display("FAIL %s wb: rw %0b busy %0b req %0b want %0b 1 0", nm, oRegWrite, oBusy, oMemReq, rdn != 5'd0);
            end
            if (rdn != 5'd0) begin
                n_checks++;
                if (oRegAddr !== rdn || oRegData !== m_load(op, a, rdata)) begin
                    n_fail++;
                    $display("FAIL %s wb_data: got r%0d=%h want r%0d=%h", nm, oRegAddr, oRegData, rdn, m_load(op, a, rdata));
                end
            end
            @(negedge iClk);
            n_checks++;
            if (oBusy !== 1'b0 || oRegWrite !== 1'b0) begin
                n_fail++; $display("FAIL %s load_done: busy %0b rw %0b want 0 0", nm, oBusy, oRegWrite);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        n_checks++;
        if ({oBusy, oMemReq, oMemWe, oRegWrite, oErr} !== 5'd0 || oErrCode !== 2'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b/%0d want 00000/0", {oBusy, oMemReq, oMemWe, oRegWrite, oErr}, oErrCode);
        end
        n_checks++;
        if (oMemAddr !== 32'd0 || oMemWdata !== 32'd0 || oMemBe !== 4'd0 || oRegAddr !== 5'd0 || oRegData !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h be %b rd %0d rdata %h want all 0", oMemAddr, oMemWdata, oMemBe, oRegAddr, oRegData);
        end
        iRst = 1'b1;
    endtask

    task automatic test_directed();
        run_txn("sb_0x103", 1'b0, 1'b1, 3'd0, 32'h103, 32'h0000_00AB, 5'd0, 0, 32'd0);
        run_txn("lb_0x102", 1'b1, 1'b0, 3'd0, 32'h102, 32'd0, 5'd5, 3, 32'h0080_0000);
        run_txn("lbu_0x102", 1'b1, 1'b0, 3'd4, 32'h102, 32'd0, 5'd5, 3, 32'h0080_0000);
        run_txn("lh_0x102", 1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 5'd9, 1, 32'h8001_1234);
        run_txn("lhu_0x100", 1'b1, 1'b0, 3'd5, 32'h100, 32'd0, 5'd9, 0, 32'h1234_F00D);
        run_txn("sh_0x202", 1'b0, 1'b1, 3'd1, 32'h202, 32'hDEAD_BEEF, 5'd0, 2, 32'd0);
        run_txn("lw_misalign", 1'b1, 1'b0, 3'd2, 32'h102, 32'd0, 5'd3, 0, 32'd0);
        run_txn("rd_wr_both", 1'b1, 1'b1, 3'd2, 32'h100, 32'd0, 5'd3, 0, 32'd0);
        run_txn("ld_op3", 1'b1, 1'b0, 3'd3, 32'h100, 32'd0, 5'd3, 0, 32'd0);
        run_txn("st_op4", 1'b0, 1'b1, 3'd4, 32'h100, 32'd0, 5'd0, 0, 32'd0);
        run_txn("lw_rd0", 1'b1, 1'b0, 3'd2, 32'h300, 32'd0, 5'd0, 1, 32'h1234_5678);
    endtask

    task automatic test_ack_outside_access();
        @(negedge iClk);
        iMemAck = 1'b1; iMemRdata = $urandom;
        @(negedge iClk);
        iMemAck = 1'b0;
        n_checks++;
        if (oBusy !== 1'b0 || oMemReq !== 1'b0 || oRegWrite !== 1'b0 || oErr !== 1'b0) begin
            n_fail++; $display("FAIL stray_ack: busy %0b req %0b rw %0b err %0b want 0 0 0 0", oBusy, oMemReq, oRegWrite, oErr);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge iClk);
        iValid = 1'b1; iRead = 1'b1; iWrite = 1'b0; iOpType = 3'd2; iAddr = 32'h40; iRdAddr = 5'd4;
        @(posedge iClk); #1;
        iValid = 1'b0; iRead = 1'b0;
        @(negedge iClk);
        n_checks++;
        if (oMemReq !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: req %0b want 1", oMemReq);
        end
        iRst = 1'b0;
        #1;
        n_checks++;
        if ({oBusy, oMemReq, oMemWe, oRegWrite, oErr} !== 5'd0 || oMemAddr !== 32'd0 || oMemBe !== 4'd0) begin
            n_fail++; $display("FAIL rst_mid_async: ctrl %b addr %h be %b want 0", {oBusy, oMemReq, oMemWe, oRegWrite, oErr}, oMemAddr, oMemBe);
        end
        @(negedge iClk);
        iRst = 1'b1;
        run_txn("sw_0x200_after_rst", 1'b0, 1'b1, 3'd2, 32'h200, 32'hCAFE_F00D, 5'd0, 0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        // Stores: command held, memory always acks; accepted every 2 cycles.
        @(negedge iClk);
        iValid = 1'b1; iWrite = 1'b1; iRead = 1'b0; iOpType = 3'd2; iAddr = 32'h480; iData = 32'h0BAD_F00D;
        iMemAck = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge iClk);
            n_checks++;
            if (oMemReq !== bit'(k % 2)) begin
                n_fail++; $display("FAIL b2b_store[%0d]: req %0b want %0b", k, oMemReq, k % 2);
            end
        end
        iValid = 1'b0; iWrite = 1'b0;
        @(negedge iClk);
        iMemAck = 1'b0;
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_store_end: busy %0b want 0", oBusy);
        end
        // Loads: accepted every 3 cycles; write-back two cycles after acceptance.
        d = $urandom;
        iMemRdata = d;
        iValid = 1'b1; iRead = 1'b1; iOpType = 3'd1; iAddr = 32'h512; iRdAddr = 5'd7;
        iMemAck = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge iClk);
            n_checks++;
            if (oMemReq !== (k % 3 == 1) || oRegWrite !== (k % 3 == 2)) begin
                n_fail++; $display("FAIL b2b_load[%0d]: req %0b rw %0b want %0b %0b", k, oMemReq, oRegWrite, k % 3 == 1, k % 3 == 2);
            end
            if (k % 3 == 2) begin
                n_checks++;
                if (oRegData !== m_load(3'd1, 32'h512, d)) begin
                    n_fail++; $display("FAIL b2b_load_data[%0d]: got %h want %h", k, oRegData, m_load(3'd1, 32'h512, d));
                end
            end
        end
        iValid = 1'b0; iRead = 1'b0;
        @(negedge iClk);
        iMemAck = 1'b0;
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_load_end: busy %0b want 0", oBusy);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge iClk);
        iValid = 1'b1; iRead = 1'b1; iWrite = 1'b0; iOpType = 3'd2; iAddr = 32'h600; iRdAddr = 5'd6;
        @(posedge iClk); #1;
        iValid = 1'b0; iRead = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge iClk);
            n_checks++;
            if (oMemReq !== 1'b1 || oErr !== 1'b0) begin
                n_fail++; $display("FAIL timeout_wait[%0d]: req %0b err %0b want 1 0", k, oMemReq, oErr);
            end
        end
        @(negedge iClk);
        n_checks++;
        if (oMemReq !== 1'b0 || oErr !== 1'b1 || oErrCode !== 2'd3 || oBusy !== 1'b0 || oRegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: req %0b err %0b code %0d busy %0b rw %0b want 0 1 3 0 0", oMemReq, oErr, oErrCode, oBusy, oRegWrite);
        end
        run_txn("ack_in_last_cycle", 1'b1, 1'b0, 3'd2, 32'h604, 32'd0, 5'd6, 3, 32'h7654_3210);
    endtask
`endif

    task automatic test_random();
        bit rd, wr;
        int sel;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 11);
            rd  = (sel == 0) || (sel >= 2 && sel < 7);
            wr  = (sel == 0) || (sel >= 7);
            run_txn($sformatf("rand%0d", n), rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ack_outside_access();
        test_reset_mid_access();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer that sits between the ALU memory-operation output and the data-memory port. Accepts one load or store command at a time, checks alignment and access size, and drives a req/ack memory handshake with byte enables. Loads are sign- or zero-extended and returned as a register write-back. The block stalls the upstream pipeline while an access is in flight.

## Interface
Parameters:
- cDataWidth, 32, data and register width (fixed at 32 for the byte-lane logic)
- cAddrWidth, 32, byte-address width
- cTimeoutCycles, 16, maximum number of ACCESS cycles without ack (used only with the timeout feature)

Ports:
- iClk  in  1  clock; all logic is on the rising edge
- iRst  in  1  asynchronous, active-low reset
- iValid  in  1  command valid
- iRead  in  1  load command
- iWrite  in  1  store command
- iOpType  in  3  funct3 access type
- iAddr  in  cAddrWidth  effective byte address (rs1 + imm)
- iData  in  cDataWidth  store data (rs2)
- iRdAddr  in  5  load destination register
- oBusy  out  1  stall to upstream; high when state is not IDLE
- oMemReq  out  1  memory request
- oMemWe  out  1  1 = write
- oMemAddr  out  cAddrWidth  word-aligned address, {addr[31:2],2'b00}
- oMemWdata  out  cDataWidth  lane-replicated write data
- oMemBe  out  4  byte enables
- iMemAck  in  1  memory accepted the request (write) or returned data (read)
- iMemRdata  in  cDataWidth  read data; valid in the cycle iMemAck is high
- oRegWrite  out  1  write-back valid, one-cycle pulse
- oRegAddr  out  5  write-back register
- oRegData  out  cDataWidth  extended load data
- oErr  out  1  error pulse, one cycle
- oErrCode  out  2  01 = misaligned, 10 = illegal, 11 = timeout

## Operation
- States: IDLE, ACCESS, WB. Reset puts the block in IDLE and drives every output to 0.
- IDLE: a command is sampled when iValid is high.
  - It is illegal when iRead and iWrite are both high or both low.
  - It is illegal for a load with iOpType in {3, 6, 7}.
  - It is illegal for a store with iOpType ≥ 3.
  - It is misaligned for a halfword with addr[0] = 1, or a word with addr[1:0] ≠ 0.
  - On an error: oErr and oErrCode are asserted for one cycle, no memory access takes place, and the state stays IDLE. Illegal is checked before misaligned.
  - Otherwise the command is latched and the state moves to ACCESS.
- ACCESS: oMemReq = 1. oMemWe, oMemAddr, oMemBe and oMemWdata are held stable until iMemAck is sampled high.
  - A write with ack goes to IDLE.
  - A read with ack captures the extracted data and goes to WB.
- WB: oRegWrite = 1 with oRegAddr/oRegData for one cycle, then IDLE. If iRdAddr = 0, the memory read still happens but oRegWrite stays 0.
- Byte enables:
  - Byte access: be = 1 << addr[1:0]; wdata = {4{data[7:0]}}.
  - Halfword access: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - Word access: be = 4'b1111.
  - Loads use the same enables.
- Load extract selects the addressed lane, then extends:
  - LB (0) and LH (1) sign-extend.
  - LBU (4) and LHU (5) zero-extend.
  - LW (2) is passed through.
- Commands presented while oBusy = 1 are ignored. Upstream holds the command until oBusy is low.

## Timing
- Command accepted at cycle T. oBusy and oMemReq are high from T+1.
- An ack is valid at the earliest in cycle T+1, giving a zero-wait access.
- For an ack at cycle A:
  - Write: oMemReq and oBusy are low at A+1.
  - Read: oRegWrite pulses at A+1, and oBusy is low at A+2.
- An error for a command at T pulses at T+1, and oBusy stays 0.
- Back-to-back throughput:
  - Stores complete every 2 cycles.
  - Loads complete every 3 cycles with zero-wait memory.
- Reset mid-ACCESS deasserts oMemReq immediately (asynchronously). The memory side must tolerate an abandoned request.
- An iMemAck outside ACCESS is ignored.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter counts ACCESS cycles. It is cleared on entry to ACCESS and sized $clog2(cTimeoutCycles+1).
  - If no ack arrives by the cTimeoutCycles-th ACCESS cycle, then at the next cycle: oMemReq = 0, oErr = 1 with oErrCode = 11, no write-back, and the state returns to IDLE.
  - An ack in the final counted cycle wins over the timeout.
- LSU_TIMEOUT_EN undefined:
  - No counter. ACCESS waits indefinitely.
  - Code 11 is never produced, and cTimeoutCycles is unused.

## Structure
- corePckg holds:
  - tLsuState enum.
  - tLsuErr enum (eErrNone, eErrMisalign, eErrIllegal, eErrTimeout).
  - Access-type constants cLsuB/H/W/BU/HU = 3'b000/001/010/100/101.
- Sub-module lsu_lane is purely combinational:
  - It takes addr[1:0], opType and store data, and produces be and wdata.
  - It takes rdata, addr[1:0] and opType, and produces the extended load data.
  - lsu_ctrl contains only the FSM, registers and timeout logic.

## Test plan
- SB at address 0x103, data 0xAB, ack at T+1: oMemAddr = 0x100, oMemBe = 4'b1000, oMemWdata = 0xABABABAB, oBusy low at T+2, no oRegWrite.
- LB at address 0x102 with rdata 0x00800000, rd = 5, ack after 3 wait cycles: oRegWrite with oRegAddr = 5 and oRegData = 0xFFFFFF80. LBU on the same data gives 0x00000080.
- LW at address 0x102: oErr with code 01 at T+1, no oMemReq, oBusy stays 0. iRead = iWrite = 1 gives code 10. Load with opType 3 gives code 10.
- LW with rd = 0 and rdata 0x12345678: the memory access completes, oRegWrite stays 0.
- iRst asserted during ACCESS with oMemReq high: all outputs are 0 immediately; after release, a new SW at 0x200 proceeds normally.
- LSU_TIMEOUT_EN with cTimeoutCycles = 4 and no ack: oMemReq drops and oErr code 11 is asserted after the 4th ACCESS cycle. An ack in the 4th cycle completes the access normally.
